// File: rtl/hazard_ctrl_pkg.sv
// Shared decode constants, instruction classes and forward-select encodings
// for the hazard controller and its per-stage decoder.
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [3:0] MD_MULT_CYC = 4'd5;
    localparam logic [3:0] MD_DIV_CYC  = 4'd10;

    // Tuse value for an operand the instruction never reads
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [2:0] FWD_D_RF    = 3'd0;
    localparam logic [2:0] FWD_D_PC8_E = 3'd1;
    localparam logic [2:0] FWD_D_PC8_M = 3'd2;
    localparam logic [2:0] FWD_D_AOM   = 3'd3;
    localparam logic [2:0] FWD_D_WD    = 3'd4;

    localparam logic [1:0] FWD_E_PIPE  = 2'd0;
    localparam logic [1:0] FWD_E_PC8_M = 2'd1;
    localparam logic [1:0] FWD_E_AOM   = 2'd2;
    localparam logic [1:0] FWD_E_WD    = 2'd3;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_CAL_R, CLS_CAL_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JR, CLS_JAL, CLS_JALR, CLS_MD, CLS_MF, CLS_MT
    } instr_cls_t;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    typedef struct packed {
        instr_cls_t cls;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [1:0] tnew;     // Tnew as seen from the E stage
    } dec_t;

    function automatic logic [3:0] md_cycles(input logic [5:0] funct);
        return (funct == FN_DIV || funct == FN_DIVU) ? MD_DIV_CYC : MD_MULT_CYC;
    endfunction

    function automatic logic is_link(input instr_cls_t c);
        return c == CLS_JAL || c == CLS_JALR;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational instruction classifier; one instance per pipeline stage.
// md/mf/mt are only recognised when HAZARD_MD_EN is defined.
module hazard_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output dec_t        dec
);

    logic [5:0] op;
    logic [5:0] fn;
    instr_cls_t cls;

    assign op = ir[31:26];
    assign fn = ir[5:0];

    always_comb begin
        cls = CLS_NOP;
        if (ir != 32'd0) begin
            case (op)
                OP_RTYPE: begin
                    case (fn)
                        FN_ADDU, FN_SUBU, FN_SLT, FN_SLL: cls = CLS_CAL_R;
                        FN_JR:                            cls = CLS_JR;
                        FN_JALR:                          cls = CLS_JALR;
`ifdef HAZARD_MD_EN
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: cls = CLS_MD;
                        FN_MFHI, FN_MFLO:                 cls = CLS_MF;
                        FN_MTHI, FN_MTLO:                 cls = CLS_MT;
`endif
                        default:                          cls = CLS_NOP;
                    endcase
                end
                OP_ORI, OP_ADDIU, OP_LUI: cls = CLS_CAL_I;
                OP_LW:                    cls = CLS_LOAD;
                OP_SW:                    cls = CLS_STORE;
                OP_BEQ:                   cls = CLS_BRANCH;
                OP_JAL:                   cls = CLS_JAL;
                default:                  cls = CLS_NOP;
            endcase
        end
    end

    always_comb begin
        dec.cls     = cls;
        dec.rs      = ir[25:21];
        dec.rt      = ir[20:16];
        dec.dst     = 5'd0;
        dec.tuse_rs = TUSE_NONE;
        dec.tuse_rt = TUSE_NONE;
        dec.tnew    = 2'd0;
        case (cls)
            CLS_CAL_R:  begin dec.dst = ir[15:11]; dec.tuse_rs = 2'd1; dec.tuse_rt = 2'd1; dec.tnew = 2'd1; end
            CLS_CAL_I:  begin dec.dst = ir[20:16]; dec.tuse_rs = 2'd1; dec.tnew = 2'd1; end
            CLS_LOAD:   begin dec.dst = ir[20:16]; dec.tuse_rs = 2'd1; dec.tnew = 2'd2; end
            CLS_STORE:  begin dec.tuse_rs = 2'd1; dec.tuse_rt = 2'd2; end
            CLS_BRANCH, CLS_JR: begin dec.tuse_rs = 2'd0; dec.tuse_rt = 2'd0; end
            CLS_JAL:    dec.dst = 5'd31;
            CLS_JALR:   dec.dst = ir[15:11];
            CLS_MD:     begin dec.tuse_rs = 2'd1; dec.tuse_rt = 2'd1; end
            CLS_MF:     begin dec.dst = ir[15:11]; dec.tnew = 2'd1; end
            CLS_MT:     dec.tuse_rs = 2'd1;
            default:    ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding selects, stall/bubble and
// the multiply/divide busy sequencer (present only with HAZARD_MD_EN).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IRD,
    input  logic [31:0] IRE,
    input  logic [31:0] IRM,
    input  logic [31:0] IRW,
    output logic [2:0]  Forward_RS_D_src,
    output logic [2:0]  Forward_RT_D_src,
    output logic [1:0]  Forward_RS_E_src,
    output logic [1:0]  Forward_RT_E_src,
    output logic        Forward_RT_M_src,
    output logic        PauseF,
    output logic        PauseD,
    output logic        ClearE,
    output logic        MDStart,
    output logic        MDBusy
);

    localparam int NUM_STAGES = 4;
    localparam int ST_D = 0;
    localparam int ST_E = 1;
    localparam int ST_M = 2;
    localparam int ST_W = 3;

    logic [NUM_STAGES-1:0][31:0] ir_stage;
    dec_t                        dec [NUM_STAGES];
    logic                        data_stall;
    logic                        md_stall;
    logic                        stall;
    logic                        unused_dec;

    assign ir_stage = {IRW, IRM, IRE, IRD};

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_dec
        hazard_decode u_dec (.ir(ir_stage[i]), .dec(dec[i]));
    end

    assign unused_dec = ^{dec[ST_D], dec[ST_E], dec[ST_M], dec[ST_W]};

    // Only a load is still in flight once it reaches M
    function automatic logic [1:0] tnew_m(input dec_t d);
        return (d.cls == CLS_LOAD) ? 2'd1 : 2'd0;
    endfunction

    // Nearest writer of r decides; if its value is not ready yet, read the RF
    function automatic logic [2:0] fwd_d(input logic [4:0] r, input dec_t e, input dec_t m, input dec_t w);
        if (r == 5'd0) return FWD_D_RF;
        if (e.dst == r) return is_link(e.cls) ? FWD_D_PC8_E : FWD_D_RF;
        if (m.dst == r) begin
            if (is_link(m.cls)) return FWD_D_PC8_M;
            return (tnew_m(m) == 2'd0) ? FWD_D_AOM : FWD_D_RF;
        end
        if (w.dst == r) return FWD_D_WD;
        return FWD_D_RF;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] r, input dec_t m, input dec_t w);
        if (r == 5'd0) return FWD_E_PIPE;
        if (m.dst == r) begin
            if (is_link(m.cls)) return FWD_E_PC8_M;
            return (tnew_m(m) == 2'd0) ? FWD_E_AOM : FWD_E_PIPE;
        end
        if (w.dst == r) return FWD_E_WD;
        return FWD_E_PIPE;
    endfunction

    function automatic logic operand_stall(input logic [4:0] r, input logic [1:0] tuse,
                                           input dec_t e, input dec_t m);
        if (r == 5'd0 || tuse == TUSE_NONE) return 1'b0;
        return (e.dst == r && e.tnew > tuse) || (m.dst == r && tnew_m(m) > tuse);
    endfunction

    assign Forward_RS_D_src = fwd_d(dec[ST_D].rs, dec[ST_E], dec[ST_M], dec[ST_W]);
    assign Forward_RT_D_src = fwd_d(dec[ST_D].rt, dec[ST_E], dec[ST_M], dec[ST_W]);
    assign Forward_RS_E_src = fwd_e(dec[ST_E].rs, dec[ST_M], dec[ST_W]);
    assign Forward_RT_E_src = fwd_e(dec[ST_E].rt, dec[ST_M], dec[ST_W]);
    assign Forward_RT_M_src = dec[ST_M].cls == CLS_STORE && dec[ST_W].dst != 5'd0
                              && dec[ST_W].dst == dec[ST_M].rt;

    assign data_stall = operand_stall(dec[ST_D].rs, dec[ST_D].tuse_rs, dec[ST_E], dec[ST_M])
                      | operand_stall(dec[ST_D].rt, dec[ST_D].tuse_rt, dec[ST_E], dec[ST_M]);
    assign md_stall   = (dec[ST_D].cls inside {CLS_MD, CLS_MF, CLS_MT}) && (MDStart || MDBusy);
    assign stall      = data_stall | md_stall;

    assign PauseF = stall;
    assign PauseD = stall;
    assign ClearE = stall;

`ifdef HAZARD_MD_EN
    md_state_t  md_state;
    logic [3:0] md_cnt;

    // The md in E always advances, so a start here is never lost to a stall
    assign MDStart = dec[ST_E].cls == CLS_MD;
    assign MDBusy  = md_state == MD_BUSY;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= 4'd0;
        end else if (MDStart) begin
            md_state <= MD_BUSY;
            md_cnt   <= md_cycles(IRE[5:0]);
        end else if (md_state == MD_BUSY) begin
            md_cnt <= md_cnt - 4'd1;
            if (md_cnt == 4'd1) md_state <= MD_IDLE;
        end
    end
`else
    logic unused_clk_rst;

    assign MDStart        = 1'b0;
    assign MDBusy         = 1'b0;
    assign unused_clk_rst = Clk ^ Reset;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// instruction mixes against a stage-availability reference model.
module tb_hazard_ctrl;

`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam int K_NOP = 0, K_CALR = 1, K_CALI = 2, K_LOAD = 3, K_STORE = 4, K_BR = 5,
                   K_JR = 6, K_JAL = 7, K_JALR = 8, K_MD = 9, K_MF = 10, K_MT = 11;
    localparam int NEVER = 9;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IRD, IRE, IRM, IRW;
    logic [2:0]  fd_rs, fd_rt;
    logic [1:0]  fe_rs, fe_rt;
    logic        fm_rt, PauseF, PauseD, ClearE, MDStart, MDBusy;
    logic [15:0] got;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int md_from  = 0;
    int md_until = -1;
    bit exp_busy = 1'b0;

    always #5 Clk = ~Clk;

    hazard_ctrl dut (
        .Clk(Clk), .Reset(Reset), .IRD(IRD), .IRE(IRE), .IRM(IRM), .IRW(IRW),
        .Forward_RS_D_src(fd_rs), .Forward_RT_D_src(fd_rt),
        .Forward_RS_E_src(fe_rs), .Forward_RT_E_src(fe_rt),
        .Forward_RT_M_src(fm_rt), .PauseF(PauseF), .PauseD(PauseD), .ClearE(ClearE),
        .MDStart(MDStart), .MDBusy(MDBusy)
    );

    assign got = {fd_rs, fd_rt, fe_rs, fe_rt, fm_rt, PauseF, PauseD, ClearE, MDStart, MDBusy};

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs, rt, rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic int kind(input logic [31:0] ir);
        if (ir == 32'd0) return K_NOP;
        case (ir[31:26])
            6'h00: case (ir[5:0])
                6'h21, 6'h23, 6'h2a, 6'h00: return K_CALR;
                6'h08: return K_JR;
                6'h09: return K_JALR;
                6'h18, 6'h19, 6'h1a, 6'h1b: return MD_EN ? K_MD : K_NOP;
                6'h10, 6'h12: return MD_EN ? K_MF : K_NOP;
                6'h11, 6'h13: return MD_EN ? K_MT : K_NOP;
                default: return K_NOP;
            endcase
            6'h0d, 6'h09, 6'h0f: return K_CALI;
            6'h23: return K_LOAD;
            6'h2b: return K_STORE;
            6'h04: return K_BR;
            6'h03: return K_JAL;
            default: return K_NOP;
        endcase
    endfunction

    function automatic logic [4:0] dest(input logic [31:0] ir);
        case (kind(ir))
            K_CALR, K_JALR, K_MF: return ir[15:11];
            K_CALI, K_LOAD:       return ir[20:16];
            K_JAL:                return 5'd31;
            default:              return 5'd0;
        endcase
    endfunction

    // Stage (D=0..W=3) from which the result can be forwarded
    function automatic int ready(input logic [31:0] ir);
        case (kind(ir))
            K_JAL, K_JALR:         return 1;
            K_CALR, K_CALI, K_MF:  return 2;
            K_LOAD:                return 3;
            default:               return NEVER;
        endcase
    endfunction

    function automatic int tuse(input logic [31:0] ir, input bit is_rt);
        case (kind(ir))
            K_BR, K_JR:    return 0;
            K_CALR, K_MD:  return 1;
            K_CALI, K_LOAD, K_MT: return is_rt ? NEVER : 1;
            K_STORE:       return is_rt ? 2 : 1;
            default:       return NEVER;
        endcase
    endfunction

    // D-style source code for reader of r, searching stages first..W
    function automatic int src_code(input logic [4:0] r, input int first, input logic [31:0] e, m, w);
        logic [31:0] st [4];
        st[0] = 32'd0; st[1] = e; st[2] = m; st[3] = w;
        if (r == 5'd0) return 0;
        for (int s = first; s <= 3; s++)
            if (dest(st[s]) == r) begin
                if (ready(st[s]) > s) return 0;
                if (s == 1) return 1;
                if (s == 3) return 4;
                return (kind(st[s]) == K_JAL || kind(st[s]) == K_JALR) ? 2 : 3;
            end
        return 0;
    endfunction

    function automatic bit data_stall(input logic [31:0] d, e, m);
        logic [31:0] st [3];
        logic [4:0]  r [2];
        int          t [2];
        st[0] = d; st[1] = e; st[2] = m;
        r[0] = d[25:21]; r[1] = d[20:16];
        t[0] = tuse(d, 1'b0); t[1] = tuse(d, 1'b1);
        for (int op = 0; op < 2; op++)
            if (r[op] != 5'd0 && t[op] != NEVER)
                for (int s = 1; s <= 2; s++)
                    if (dest(st[s]) == r[op] && ready(st[s]) - s > t[op]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] model(input logic [31:0] d, e, m, w, input bit busy);
        int cd_rs, cd_rt, ce_rs, ce_rt;
        bit start, stall, fm;
        cd_rs = src_code(d[25:21], 1, e, m, w);
        cd_rt = src_code(d[20:16], 1, e, m, w);
        ce_rs = src_code(e[25:21], 2, e, m, w);
        ce_rt = src_code(e[20:16], 2, e, m, w);
        if (ce_rs != 0) ce_rs = ce_rs - 1;
        if (ce_rt != 0) ce_rt = ce_rt - 1;
        start = kind(e) == K_MD;
        stall = data_stall(d, e, m) ||
                ((kind(d) == K_MD || kind(d) == K_MF || kind(d) == K_MT) && (start || busy));
        fm = kind(m) == K_STORE && dest(w) != 5'd0 && dest(w) == m[20:16];
        return {3'(cd_rs), 3'(cd_rt), 2'(ce_rs), 2'(ce_rt), fm, {3{stall}}, start, busy};
    endfunction

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  a, b, c;
        logic [15:0] imm;
        a = rreg(); b = rreg(); c = rreg(); imm = 16'($urandom_range(0, 65535));
        case ($urandom_range(0, 21))
            0:  return rtype(6'h21, a, b, c);
            1:  return rtype(6'h23, a, b, c);
            2:  return rtype(6'h2a, a, b, c);
            3:  return rtype(6'h00, 5'd0, b, c);
            4:  return itype(6'h0d, a, b, imm);
            5:  return itype(6'h09, a, b, imm);
            6:  return itype(6'h0f, 5'd0, b, imm);
            7:  return itype(6'h23, a, b, imm);
            8:  return itype(6'h2b, a, b, imm);
            9:  return itype(6'h04, a, b, imm);
            10: return rtype(6'h08, a, 5'd0, 5'd0);
            11: return {6'h03, 26'h0000100};
            12: return rtype(6'h09, a, 5'd0, c);
            13: return rtype(6'h18, a, b, 5'd0);
            14: return rtype(6'h19, a, b, 5'd0);
            15: return rtype(6'h1a, a, b, 5'd0);
            16: return rtype(6'h1b, a, b, 5'd0);
            17: return rtype(6'h10, 5'd0, 5'd0, c);
            18: return rtype(6'h12, 5'd0, 5'd0, c);
            19: return rtype(6'h11, a, 5'd0, 5'd0);
            20: return rtype(6'h13, a, 5'd0, 5'd0);
            default: return 32'd0;
        endcase
    endfunction

    // One pipeline cycle: new IRs after the edge, outputs sampled at negedge
    task automatic apply(input logic [31:0] d, e, m, w);
        @(posedge Clk);
        #1;
        IRD = d; IRE = e; IRM = m; IRW = w;
        cyc++;
        exp_busy = MD_EN && cyc > md_from && cyc <= md_until;
        if (kind(e) == K_MD) begin
            md_from  = cyc;
            md_until = cyc + ((e[5:0] == 6'h1a || e[5:0] == 6'h1b) ? 10 : 5);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; IRD = 32'd0; IRE = 32'd0; IRM = 32'd0; IRW = 32'd0;
        #2;
        total++;
        if (got !== 16'd0) begin bad++; $display("FAIL reset_in: got %h want 0000", got); end
        @(negedge Clk);
        Reset = 1'b0;
        md_until = -1;
        apply(32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (got !== 16'd0) begin bad++; $display("FAIL reset_idle: got %h want 0000", got); end
    endtask

    task automatic test_load_use();
        logic [31:0] lw, add;
        lw  = itype(6'h23, 5'd0, 5'd1, 16'd4);
        add = rtype(6'h21, 5'd1, 5'd1, 5'd2);
        apply(add, lw, 32'd0, 32'd0);
        total++;
        if ({PauseF, PauseD, ClearE} !== 3'b111) begin bad++; $display("FAIL load_use_stall: got %b want 111", {PauseF, PauseD, ClearE}); end
        apply(add, 32'd0, lw, 32'd0);
        total++;
        if (PauseD !== 1'b0) begin bad++; $display("FAIL load_use_release: got %b want 0", PauseD); end
        apply(32'd0, add, 32'd0, lw);
        total++;
        if ({fe_rs, fe_rt} !== 4'b1111) begin bad++; $display("FAIL load_use_fwd_e: got %b want 1111", {fe_rs, fe_rt}); end
    endtask

    task automatic test_branch_alu();
        logic [31:0] add, beq;
        add = rtype(6'h21, 5'd2, 5'd3, 5'd1);
        beq = itype(6'h04, 5'd1, 5'd0, 16'h0010);
        apply(beq, add, 32'd0, 32'd0);
        total++;
        if (PauseD !== 1'b1) begin bad++; $display("FAIL branch_stall: got %b want 1", PauseD); end
        apply(beq, 32'd0, add, 32'd0);
        total++;
        if (fd_rs !== 3'd3 || PauseD !== 1'b0) begin bad++; $display("FAIL branch_fwd: got sel=%0d stall=%b want sel=3 stall=0", fd_rs, PauseD); end
    endtask

    task automatic test_link();
        logic [31:0] jal, jr;
        jal = {6'h03, 26'h0000100};
        jr  = rtype(6'h08, 5'd31, 5'd0, 5'd0);
        apply(jr, jal, 32'd0, 32'd0);
        total++;
        if (fd_rs !== 3'd1 || PauseD !== 1'b0) begin bad++; $display("FAIL link_e: got sel=%0d stall=%b want sel=1 stall=0", fd_rs, PauseD); end
        apply(jr, 32'd0, jal, 32'd0);
        total++;
        if (fd_rs !== 3'd2) begin bad++; $display("FAIL link_m: got %0d want 2", fd_rs); end
    endtask

    task automatic test_reg_zero();
        logic [31:0] w0, add3;
        w0   = rtype(6'h21, 5'd1, 5'd2, 5'd0);
        add3 = rtype(6'h21, 5'd0, 5'd0, 5'd3);
        apply(add3, w0, w0, w0);
        total++;
        if (got[15:3] !== 13'd0) begin bad++; $display("FAIL reg_zero: got %b want all zero", got[15:3]); end
    endtask

    task automatic test_store();
        logic [31:0] sw5;
        sw5 = itype(6'h2b, 5'd0, 5'd5, 16'd0);
        apply(32'd0, 32'd0, sw5, rtype(6'h21, 5'd1, 5'd2, 5'd5));
        total++;
        if (fm_rt !== 1'b1) begin bad++; $display("FAIL store_fwd: got %b want 1", fm_rt); end
        apply(32'd0, 32'd0, sw5, rtype(6'h21, 5'd1, 5'd2, 5'd6));
        total++;
        if (fm_rt !== 1'b0) begin bad++; $display("FAIL store_nofwd: got %b want 0", fm_rt); end
    endtask

    task automatic test_md(input logic [5:0] fn, input int n);
        logic [31:0] mflo;
        int stalls, busys;
        mflo = rtype(6'h12, 5'd0, 5'd0, 5'd4);
        apply(mflo, rtype(fn, 5'd1, 5'd2, 5'd0), 32'd0, 32'd0);
        stalls = PauseD ? 1 : 0;
        busys  = 0;
        total++;
        if (MDStart !== MD_EN) begin bad++; $display("FAIL md_start_%0d: got %b want %b", n, MDStart, MD_EN); end
        for (int i = 0; i < 25; i++) begin
            apply(mflo, 32'd0, 32'd0, 32'd0);
            if (PauseD) stalls++;
            if (MDBusy) busys++;
        end
        total++;
        if (stalls !== (MD_EN ? n + 1 : 0)) begin bad++; $display("FAIL md_stall_%0d: got %0d want %0d", n, stalls, MD_EN ? n + 1 : 0); end
        total++;
        if (busys !== (MD_EN ? n : 0)) begin bad++; $display("FAIL md_busy_%0d: got %0d want %0d", n, busys, MD_EN ? n : 0); end
    endtask

    task automatic test_reset_div();
        logic [31:0] mflo;
        mflo = rtype(6'h12, 5'd0, 5'd0, 5'd4);
        apply(mflo, rtype(6'h1a, 5'd1, 5'd2, 5'd0), 32'd0, 32'd0);
        for (int k = 1; k <= 4; k++) apply(mflo, 32'd0, 32'd0, 32'd0);
        total++;
        if ({MDBusy, PauseD} !== {MD_EN, MD_EN}) begin bad++; $display("FAIL div_mid: got %b want %b", {MDBusy, PauseD}, {MD_EN, MD_EN}); end
        #1 Reset = 1'b1;
        #1;
        md_until = -1;
        total++;
        if ({MDBusy, PauseD, ClearE} !== 3'b000) begin bad++; $display("FAIL div_reset: got %b want 000", {MDBusy, PauseD, ClearE}); end
        #1 Reset = 1'b0;
        apply(mflo, 32'd0, 32'd0, 32'd0);
        total++;
        if (PauseD !== 1'b0) begin bad++; $display("FAIL div_after_reset: got %b want 0", PauseD); end
    endtask

    task automatic test_random();
        logic [15:0] exp;
        for (int i = 0; i < 400; i++) begin
            apply(rand_instr(), rand_instr(), rand_instr(), rand_instr());
            exp = model(IRD, IRE, IRM, IRW, exp_busy);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random cyc=%0d ir=%h/%h/%h/%h: got %b want %b", cyc, IRD, IRE, IRM, IRW, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_alu();
        test_link();
        test_reg_zero();
        test_store();
        test_md(6'h18, 5);
        test_md(6'h1a, 10);
        test_reset_div();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
